// File: rtl/alu_register_file.sv
// alu_register_file: 2R/1W register file with write-first bypass
// and NZCV status register feeding the ALU.
module alu_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_addr0,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    output logic [DATA_WIDTH-1:0] read_data0,
    output logic [DATA_WIDTH-1:0] read_data1,
    input  logic                  write_en,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  flags_en,
    input  logic                  flag_z,
    input  logic                  flag_v,
    input  logic                  flag_c,
    input  logic                  flag_n,
    output logic [3:0]            status
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit ZR    = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [3:0]            status_q;
    logic [3:0]            status_d;
    logic                  wr_ok;

    // A write is effective unless it targets the hardwired zero register
    always_comb begin
        wr_ok = write_en;
        if (ZR && (write_addr == '0)) begin
            wr_ok = 1'b0;
        end
    end

    // Port 0: array read, overridden by bypass, zero reg and reset
    always_comb begin
        read_data0 = regs_q[read_addr0];
        if (wr_ok && (write_addr == read_addr0)) begin
            read_data0 = write_data;
        end
        if (ZR && (read_addr0 == '0)) begin
            read_data0 = '0;
        end
        if (!rst_n) begin
            read_data0 = '0;
        end
    end

    // Port 1: same resolution as port 0, independently
    always_comb begin
        read_data1 = regs_q[read_addr1];
        if (wr_ok && (write_addr == read_addr1)) begin
            read_data1 = write_data;
        end
        if (ZR && (read_addr1 == '0)) begin
            read_data1 = '0;
        end
        if (!rst_n) begin
            read_data1 = '0;
        end
    end

    // Register array: async clear, single synchronous write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_ok) begin
            regs_q[write_addr] <= write_data;
        end
    end

    // Status next state: load {N,Z,C,V} on command, otherwise hold
    always_comb begin
        status_d = status_q;
        if (flags_en) begin
            status_d = {flag_n, flag_z, flag_c, flag_v};
        end
    end

    // Status register: no bypass, visible after the loading edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= 4'b0000;
        end else begin
            status_q <= status_d;
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_alu_register_file.sv
// tb_alu_register_file: directed and random checks of the register
// file against an array-based reference model.
module tb_alu_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  read_addr0, read_addr1, write_addr;
    logic [31:0] read_data0, read_data1, write_data;
    logic        write_en, flags_en;
    logic        flag_z, flag_v, flag_c, flag_n;
    logic [3:0]  status;

    logic [31:0] mregs [32];
    logic [3:0]  mstat;
    int          errors = 0;
    int          checks = 0;

    alu_register_file dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_addr0 (read_addr0),
        .read_addr1 (read_addr1),
        .read_data0 (read_data0),
        .read_data1 (read_data1),
        .write_en   (write_en),
        .write_addr (write_addr),
        .write_data (write_data),
        .flags_en   (flags_en),
        .flag_z     (flag_z),
        .flag_v     (flag_v),
        .flag_c     (flag_c),
        .flag_n     (flag_n),
        .status     (status)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected read value straight from the behavioural rules
    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (!rst_n || a == 5'd0) return 32'h0;
        if (write_en && write_addr == a) return write_data;
        return mregs[a];
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mregs[i] = 32'h0;
        mstat = 4'b0000;
    endtask

    // Advance one rising edge and apply it to the model
    task automatic cycle();
        @(posedge clk);
        if (rst_n) begin
            if (write_en && write_addr != 5'd0) mregs[write_addr] = write_data;
            if (flags_en) mstat = {flag_n, flag_z, flag_c, flag_v};
        end
        #1;
    endtask

    task automatic check_ports(input string tag);
        #1;
        chk({tag, "_rd0"}, read_data0, exp_rd(read_addr0));
        chk({tag, "_rd1"}, read_data1, exp_rd(read_addr1));
    endtask

    initial begin
        model_clear();
        rst_n = 1'b0;
        write_en = 1'b1; write_addr = 5'd3; write_data = 32'hDEADBEEF;
        read_addr0 = 5'd3; read_addr1 = 5'd3;
        flags_en = 1'b1;
        {flag_n, flag_z, flag_c, flag_v} = 4'b1111;

        // Reset held with a write and flag load pending
        repeat (3) cycle();
        chk("rst_rd0", read_data0, 32'h0);
        chk("rst_rd1", read_data1, 32'h0);
        chk("rst_status", {28'h0, status}, 32'h0);

        rst_n = 1'b1; write_en = 1'b0; flags_en = 1'b0;
        cycle();
        check_ports("post_rst_r3");

        // Write r5, then read both ports
        write_en = 1'b1; write_addr = 5'd5; write_data = 32'h12345678;
        cycle();
        write_en = 1'b0; read_addr0 = 5'd5; read_addr1 = 5'd5;
        #1;
        chk("wr_r5_rd0", read_data0, 32'h12345678);
        chk("wr_r5_rd1", read_data1, 32'h12345678);
        read_addr1 = 5'd6;
        #1;
        chk("r6_untouched", read_data1, 32'h0);

        // Same-cycle bypass before the edge
        write_en = 1'b1; write_addr = 5'd7; write_data = 32'hA5A5A5A5;
        read_addr1 = 5'd7;
        #1;
        chk("bypass_rd1", read_data1, 32'hA5A5A5A5);
        chk("bypass_rd0_r5", read_data0, 32'h12345678);
        cycle();
        write_en = 1'b0;
        check_ports("after_bypass");

        // Zero register: bypass suppressed, write dropped
        write_en = 1'b1; write_addr = 5'd0; write_data = 32'hFFFFFFFF;
        read_addr0 = 5'd0; read_addr1 = 5'd0;
        #1;
        chk("zr_wcyc_rd0", read_data0, 32'h0);
        chk("zr_wcyc_rd1", read_data1, 32'h0);
        cycle();
        write_en = 1'b0;
        #1;
        chk("zr_after_rd0", read_data0, 32'h0);
        chk("zr_after_rd1", read_data1, 32'h0);

        // Flags load and hold, with no bypass onto status
        flags_en = 1'b1;
        {flag_n, flag_z, flag_c, flag_v} = 4'b1010;
        #1;
        chk("flags_no_bypass", {28'h0, status}, 32'h0);
        cycle();
        chk("flags_load", {28'h0, status}, 32'hA);
        flags_en = 1'b0;
        {flag_n, flag_z, flag_c, flag_v} = 4'b1111;
        cycle();
        chk("flags_hold", {28'h0, status}, 32'hA);

        // Randomised traffic against the model
        for (int k = 0; k < 300; k++) begin
            read_addr0 = 5'($urandom_range(0, 31));
            read_addr1 = ($urandom_range(0, 3) == 0) ? read_addr0
                         : 5'($urandom_range(0, 31));
            write_en   = ($urandom_range(0, 2) != 0);
            write_addr = ($urandom_range(0, 2) == 0) ? read_addr1
                         : 5'($urandom_range(0, 31));
            write_data = $urandom;
            flags_en   = $urandom_range(0, 1) == 1;
            {flag_n, flag_z, flag_c, flag_v} = 4'($urandom_range(0, 15));
            check_ports("rand");
            cycle();
            chk("rand_status", {28'h0, status}, {28'h0, mstat});
        end

        // Full readback of the array after random traffic
        write_en = 1'b0; flags_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            read_addr0 = 5'(a); read_addr1 = 5'(31 - a);
            check_ports("readback");
        end

        // Fill r1..r31 with their index, then async reset between edges
        write_en = 1'b1;
        for (int a = 1; a < 32; a++) begin
            write_addr = 5'(a); write_data = 32'(a);
            cycle();
        end
        write_en = 1'b0;
        flags_en = 1'b1;
        {flag_n, flag_z, flag_c, flag_v} = 4'b0101;
        cycle();
        flags_en = 1'b0;
        read_addr0 = 5'd17; read_addr1 = 5'd31;
        #1;
        chk("fill_r17", read_data0, 32'd17);
        chk("fill_r31", read_data1, 32'd31);
        chk("fill_status", {28'h0, status}, 32'h5);

        write_en = 1'b1; write_addr = 5'd9; write_data = 32'hCAFEF00D;
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("async_status", {28'h0, status}, 32'h0);
        for (int a = 0; a < 32; a++) begin
            read_addr0 = 5'(a); read_addr1 = 5'(a);
            check_ports("async_rst");
        end
        rst_n = 1'b1; write_en = 1'b0;
        cycle();
        for (int a = 0; a < 32; a++) begin
            read_addr0 = 5'(a); read_addr1 = 5'(31 - a);
            check_ports("post_async");
        end
        chk("post_async_status", {28'h0, status}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
